// File: rtl/bsg_hp0_burst_writer.sv
// bsg_hp0_burst_writer: AXI4 write-burst master for the HP0 port.
// Drains a 32b word stream into DRAM as INCR bursts that never cross a 4KB
// page. Only one burst is outstanding at a time. One done_o pulse is produced per job.
// Optional feature macro: BSG_HP0_BURST_WRITER_PERF_EN adds perf_stall_cnt_o,
// a saturating count of cycles where write data was offered but not accepted.
module bsg_hp0_burst_writer #(
  parameter int         C_HP0_AXI_ADDR_WIDTH = 32,
  parameter int         C_HP0_AXI_DATA_WIDTH = 32,
  parameter int         MAX_BURST            = 16,
  parameter int         LEN_WIDTH            = 20,
  parameter logic [5:0] AXI_ID               = 6'd0
) (
`ifdef BSG_HP0_BURST_WRITER_PERF_EN
  output logic [31:0]                         perf_stall_cnt_o,
`endif
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                start_i,
  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [LEN_WIDTH-1:0]                len_words_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  input  logic [C_HP0_AXI_DATA_WIDTH-1:0]     data_i,
  input  logic                                v_i,
  output logic                                ready_o,
  output logic [C_HP0_AXI_ADDR_WIDTH-1:0]     hp0_axi_awaddr,
  output logic                                hp0_axi_awvalid,
  output logic [5:0]                          hp0_axi_awid,
  output logic                                hp0_axi_awlock,
  output logic [3:0]                          hp0_axi_awcache,
  output logic [2:0]                          hp0_axi_awprot,
  output logic [7:0]                          hp0_axi_awlen,
  output logic [2:0]                          hp0_axi_awsize,
  output logic [1:0]                          hp0_axi_awburst,
  output logic [3:0]                          hp0_axi_awqos,
  input  logic                                hp0_axi_awready,
  output logic [C_HP0_AXI_DATA_WIDTH-1:0]     hp0_axi_wdata,
  output logic                                hp0_axi_wvalid,
  output logic [5:0]                          hp0_axi_wid,
  output logic                                hp0_axi_wlast,
  output logic [C_HP0_AXI_DATA_WIDTH/8-1:0]   hp0_axi_wstrb,
  input  logic                                hp0_axi_wready,
  output logic                                hp0_axi_bready,
  input  logic                                hp0_axi_bvalid,
  input  logic [5:0]                          hp0_axi_bid,
  input  logic [1:0]                          hp0_axi_bresp
);

  localparam int AW       = C_HP0_AXI_ADDR_WIDTH;
  localparam int DW       = C_HP0_AXI_DATA_WIDTH;
  localparam int BPB      = DW / 8;
  localparam int SIZE_LOG = $clog2(BPB);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BPB - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t               state_q;
  logic [AW-1:0]        curAddr_q;
  logic [LEN_WIDTH-1:0] remain_q;
  logic [8:0]           beats_q;
  logic [7:0]           awLen_q;
  logic [7:0]           beatCnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  // Beats in the next burst: limited by words left, MAX_BURST and room left in the 4KB page.
  function automatic logic [8:0] calcBeats(input logic [AW-1:0] addr,
                                           input logic [LEN_WIDTH-1:0] rem);
    logic [12:0] pageBytes;
    logic [12:0] pageBeats;
    logic [8:0]  beats;
    pageBytes = 13'd4096 - {1'b0, addr[11:0]};
    pageBeats = pageBytes >> SIZE_LOG;
    beats     = 9'(MAX_BURST);
    if (pageBeats < 13'(MAX_BURST)) beats = pageBeats[8:0];
    if (32'(rem) < 32'(beats)) beats = 9'(rem);
    return beats;
  endfunction

  logic [AW-1:0] alignedBase;
  logic [8:0]    startBeats;
  logic [8:0]    nextBeats;
  logic [8:0]    startLenFull;
  logic [8:0]    nextLenFull;
  logic          wXfer;
  logic          lastBeat;

  assign alignedBase  = base_addr_i & ALIGN_MASK;
  assign startBeats   = calcBeats(alignedBase, len_words_i);
  assign nextBeats    = calcBeats(curAddr_q, remain_q);
  assign startLenFull = startBeats - 9'd1;
  assign nextLenFull  = nextBeats - 9'd1;
  assign lastBeat     = (beatCnt_q == awLen_q);
  assign wXfer        = (state_q == S_W) && v_i && hp0_axi_wready;

  // Job FSM: latches the job, sizes each burst, and walks AW -> W -> B until all words are sent.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      curAddr_q <= '0;
      remain_q  <= '0;
      beats_q   <= '0;
      awLen_q   <= '0;
      beatCnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            if (len_words_i != '0) begin
              curAddr_q <= alignedBase;
              remain_q  <= len_words_i;
              beats_q   <= startBeats;
              awLen_q   <= startLenFull[7:0];
              state_q   <= S_AW;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_AW: begin
          if (hp0_axi_awready) begin
            curAddr_q <= curAddr_q + (AW'(beats_q) << SIZE_LOG);
            remain_q  <= remain_q - LEN_WIDTH'(beats_q);
            beatCnt_q <= '0;
            state_q   <= S_W;
          end
        end
        S_W: begin
          if (wXfer) begin
            beatCnt_q <= beatCnt_q + 8'd1;
            if (lastBeat) state_q <= S_B;
          end
        end
        S_B: begin
          if (hp0_axi_bvalid) begin
            if (hp0_axi_bresp != 2'b00) err_q <= 1'b1;
            if (remain_q != '0) begin
              beats_q <= nextBeats;
              awLen_q <= nextLenFull[7:0];
              state_q <= S_AW;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BSG_HP0_BURST_WRITER_PERF_EN
  logic [31:0] stallCnt_q;

  // Saturating count of W-state cycles where data is offered but the port is not ready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stallCnt_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      stallCnt_q <= '0;
    end else if (state_q == S_W && v_i && !hp0_axi_wready && stallCnt_q != 32'hFFFF_FFFF) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stallCnt_q;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  assign hp0_axi_awaddr  = curAddr_q;
  assign hp0_axi_awvalid = (state_q == S_AW);
  assign hp0_axi_awid    = AXI_ID;
  assign hp0_axi_awlock  = 1'b0;
  assign hp0_axi_awcache = 4'b0011;
  assign hp0_axi_awprot  = 3'b000;
  assign hp0_axi_awlen   = awLen_q;
  assign hp0_axi_awsize  = 3'(SIZE_LOG);
  assign hp0_axi_awburst = 2'b01;
  assign hp0_axi_awqos   = 4'b0000;

  assign hp0_axi_wdata  = data_i;
  assign hp0_axi_wvalid = (state_q == S_W) && v_i;
  assign hp0_axi_wid    = AXI_ID;
  assign hp0_axi_wlast  = (state_q == S_W) && lastBeat;
  assign hp0_axi_wstrb  = '1;
  assign ready_o        = (state_q == S_W) && hp0_axi_wready;

  assign hp0_axi_bready = (state_q == S_B);

  logic unused;
  assign unused = ^hp0_axi_bid;

endmodule
